// File: rtl/count_direction_decoder.sv
// Monitors a free-running count bus, classifies each step (up/down/hold/jump),
// recovers the counting direction and reports lock, illegal steps and reversals.
module count_direction_decoder #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_LEN = 4
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] COUNT_IN,
    output logic             DIRECTION_OUT,
    output logic             LOCKED,
    output logic             STEP_ERR,
    output logic             REVERSAL,
    output logic [7:0]       REVERSAL_COUNT
);

    typedef enum logic [1:0] {IDLE, SEEK, UP, DOWN} state_t;
    typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_JUMP} step_t;

    localparam logic [3:0]       RUN_MAX = 4'(LOCK_LEN);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state, state_nxt;
    step_t            step;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] diff;
    logic [3:0]       run, run_nxt;
    logic             dir_nxt;
    logic             err_nxt;
    logic             rev_nxt;
    logic             locked_nxt;

    // Modulo subtraction makes max->0 an up step and 0->max a down step.
    always_comb begin
        diff = COUNT_IN - prev;
        if (diff == ONE)
            step = STEP_UP;
        else if (diff == '1)
            step = STEP_DOWN;
        else if (diff == '0)
            step = STEP_HOLD;
        else
            step = STEP_JUMP;
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        dir_nxt   = DIRECTION_OUT;
        err_nxt   = 1'b0;
        rev_nxt   = 1'b0;
        case (state)
            IDLE: state_nxt = SEEK;
            SEEK: begin
                case (step)
                    STEP_UP:   begin state_nxt = UP;   run_nxt = 4'd1; dir_nxt = 1'b1; end
                    STEP_DOWN: begin state_nxt = DOWN; run_nxt = 4'd1; dir_nxt = 1'b0; end
                    STEP_JUMP: err_nxt = 1'b1;
                    default:   ;
                endcase
            end
            UP, DOWN: begin
                // A step in the tracked direction extends the run; the opposite one reverses.
                if ((step == STEP_UP && state == UP) || (step == STEP_DOWN && state == DOWN)) begin
                    run_nxt = (run < RUN_MAX) ? run + 4'd1 : RUN_MAX;
                end else if (step == STEP_UP || step == STEP_DOWN) begin
                    state_nxt = (step == STEP_UP) ? UP : DOWN;
                    run_nxt   = 4'd1;
                    dir_nxt   = (step == STEP_UP);
                    rev_nxt   = LOCKED;
                end else if (step == STEP_JUMP) begin
                    state_nxt = SEEK;
                    run_nxt   = 4'd0;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        locked_nxt = (state_nxt == UP || state_nxt == DOWN) && (run_nxt >= RUN_MAX);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            prev           <= '0;
            run            <= '0;
            DIRECTION_OUT  <= 1'b1;
            LOCKED         <= 1'b0;
            STEP_ERR       <= 1'b0;
            REVERSAL       <= 1'b0;
            REVERSAL_COUNT <= '0;
        end else begin
            state         <= state_nxt;
            prev          <= COUNT_IN;
            run           <= run_nxt;
            DIRECTION_OUT <= dir_nxt;
            LOCKED        <= locked_nxt;
            STEP_ERR      <= err_nxt;
            REVERSAL      <= rev_nxt;
            if (rev_nxt && REVERSAL_COUNT != 8'hFF)
                REVERSAL_COUNT <= REVERSAL_COUNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_count_direction_decoder.sv
// Directed-vector bench for count_direction_decoder (default instance plus a LOCK_LEN=1 instance).
module tb_count_direction_decoder;

    logic       clock;
    logic       reset_n;
    logic [3:0] count_in;
    logic       direction_out, locked, step_err, reversal;
    logic [7:0] reversal_count;

    logic [3:0] l1_count;
    logic       l1_direction, l1_locked, l1_step_err, l1_reversal;
    logic [7:0] l1_reversal_count;

    int checks = 0;
    int errors = 0;

    count_direction_decoder #(.WIDTH(4), .LOCK_LEN(4)) u_dut (
        .CLOCK(clock), .RESET_N(reset_n), .COUNT_IN(count_in),
        .DIRECTION_OUT(direction_out), .LOCKED(locked), .STEP_ERR(step_err),
        .REVERSAL(reversal), .REVERSAL_COUNT(reversal_count)
    );

    count_direction_decoder #(.WIDTH(4), .LOCK_LEN(1)) u_dut_l1 (
        .CLOCK(clock), .RESET_N(reset_n), .COUNT_IN(l1_count),
        .DIRECTION_OUT(l1_direction), .LOCKED(l1_locked), .STEP_ERR(l1_step_err),
        .REVERSAL(l1_reversal), .REVERSAL_COUNT(l1_reversal_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic dir, input logic lck,
                              input logic err, input logic rev, input logic [7:0] rcnt);
        check({tag, ".dir"},  {31'd0, direction_out}, {31'd0, dir});
        check({tag, ".lock"}, {31'd0, locked},        {31'd0, lck});
        check({tag, ".err"},  {31'd0, step_err},      {31'd0, err});
        check({tag, ".rev"},  {31'd0, reversal},      {31'd0, rev});
        check({tag, ".rcnt"}, {24'd0, reversal_count}, {24'd0, rcnt});
    endtask

    task automatic step(input logic [3:0] v);
        @(negedge clock);
        count_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic step_l1(input logic [3:0] v);
        @(negedge clock);
        l1_count = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        count_in = 4'd0;
        l1_count = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Count up from reset release: lock on edge 5.
        step(4'd0);
        expect_out("idle_cap", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int v = 1; v <= 3; v++) begin
            step(4'(v));
            expect_out("acquire", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        step(4'd4);
        expect_out("lock_e5", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        step(4'd5);
        expect_out("lock_e6", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        // 6..15, wrap to 0, on to 3; stays locked up.
        for (int i = 6; i <= 19; i++) begin
            step(4'(i));
            expect_out("wrap_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        end

        // Jump from 3 to 7 while locked up.
        step(4'd7);
        expect_out("jump", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(4'd8);
        expect_out("reenter", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(4'd9);
        expect_out("run2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(4'd10);
        expect_out("run3", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 11; i <= 25; i++) begin
            step(4'(i));
            expect_out("relock_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        end

        // Locked up at 9, reverse to 8..4.
        step(4'd8);
        expect_out("rev1", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        step(4'd7);
        expect_out("down_r2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        step(4'd6);
        expect_out("down_r3", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        step(4'd5);
        expect_out("down_lock", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        step(4'd4);
        expect_out("down_4", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);

        // Down through 0->15 wrap, to 6.
        for (int i = 19; i >= 6; i--) begin
            step(4'(i));
            expect_out("wrap_down", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        end

        repeat (5) begin
            step(4'd6);
            expect_out("hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        end
        step(4'd5);
        expect_out("after_hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);

        // Build REVERSAL_COUNT up to 3.
        step(4'd6);
        expect_out("rev2", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        step(4'd7);
        step(4'd8);
        expect_out("up_r3", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        step(4'd9);
        expect_out("up_lock", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        step(4'd8);
        expect_out("rev3", 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
        step(4'd7);
        step(4'd6);
        step(4'd5);
        expect_out("down_lock2", 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        count_in = 4'd11;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        expect_out("post_rst_cap", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(4'd3);
        expect_out("seek_jump", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(4'd4);
        expect_out("seek_up", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // LOCK_LEN=1 instance: every alternation after the first step is a locked reversal.
        step_l1(4'd1);
        check("l1_first.lock", {31'd0, l1_locked}, 32'd1);
        check("l1_first.rev", {31'd0, l1_reversal}, 32'd0);
        step_l1(4'd0);
        check("l1_rev1.rev", {31'd0, l1_reversal}, 32'd1);
        check("l1_rev1.rcnt", {24'd0, l1_reversal_count}, 32'd1);
        check("l1_rev1.dir", {31'd0, l1_direction}, 32'd0);
        for (int i = 0; i < 298; i++) begin
            step_l1((i % 2 == 0) ? 4'd1 : 4'd0);
            if (i == 252)
                check("l1_254.rcnt", {24'd0, l1_reversal_count}, 32'd254);
        end
        check("l1_sat.rcnt", {24'd0, l1_reversal_count}, 32'd255);
        check("l1_sat.rev", {31'd0, l1_reversal}, 32'd1);
        check("l1_sat.lock", {31'd0, l1_locked}, 32'd1);
        check("l1_sat.err", {31'd0, l1_step_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
